mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive DMA grants while the CPU waits.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- c_req, in, 1, CPU access request.
- c_we, in, 1, CPU write.
- c_addr, in, ADDR_W, CPU address.
- c_wdata, in, DATA_W, CPU write data.
- c_gnt, out, 1, CPU access accepted this cycle.
- c_rvalid, out, 1, CPU read data valid.
- c_rdata, out, DATA_W, CPU read data.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the CPU ports, for the DMA/loader requester.
- mem_en, out, 1, memory access strobe.
- mem_we, out, 1, memory write.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, synchronous memory read data, valid 1 cycle after mem_en.

Function
REQ-003 Arbitration SHALL be combinational within the cycle: each cycle the block grants at most one requester, and c_gnt and d_gnt SHALL never both be 1.
REQ-004 In a granted cycle: mem_en=1, and mem_we/mem_addr/mem_wdata SHALL equal the granted requester's inputs. In a cycle with no grant: mem_en=0, mem_we=0.
REQ-005 When only one requester asserts req, that requester SHALL be granted in the same cycle.
REQ-006 Tie (c_req=d_req=1) SHALL be resolved as follows:
- last=CPU: grant DMA.
- last=DMA and burst_cnt<MAX_BURST: grant DMA.
- last=DMA and burst_cnt==MAX_BURST: grant CPU.
REQ-007 State register last ∈ {CPU, DMA} SHALL update to the granted requester on each grant and hold on idle cycles.
REQ-008 burst_cnt (width clog2(MAX_BURST)+1) SHALL update as follows:
- DMA grant with last=DMA: saturating increment, capped at MAX_BURST.
- DMA grant with last=CPU: load 1.
- CPU grant: clear to 0.
- Idle cycle: hold.
REQ-009 A granted read (we=0) SHALL produce exactly one rvalid pulse to the same requester in the next cycle, with rdata=mem_rdata. A granted write SHALL produce no rvalid.
REQ-010 The read-return owner SHALL be a registered tag. c_rdata/d_rdata SHALL be driven to 0 when the corresponding rvalid=0.
REQ-011 Requesters hold req/we/addr/wdata stable until gnt. A requester may re-request in the cycle its rvalid returns, and back-to-back grants (one per cycle) SHALL be supported.
REQ-012 If a requester deasserts req before gnt, no access SHALL occur for it, and arbitration state SHALL be unchanged by that request.

Reset
REQ-013 While reset=0, outputs SHALL be:
- c_gnt=d_gnt=0.
- c_rvalid=d_rvalid=0.
- mem_en=mem_we=0.
- mem_addr=0, mem_wdata=0.
REQ-014 Reset SHALL set last=DMA (so the CPU wins the first tie), burst_cnt=0, and clear the read-return tag.
REQ-015 Reset asserted while a read is in flight SHALL drop it: no rvalid after reset release.
REQ-016 The first grant SHALL be possible in the first rising edge cycle after reset deasserts.

Structure
REQ-017 A shared package SHALL hold the owner encoding (OWN_CPU, OWN_DMA) and the default widths ADDR_W/DATA_W.
REQ-018 One sub-module, arb_burst_ctr, SHALL implement last/burst_cnt and the tie decision. The top level holds the datapath mux and the read-return tag.

Verification
REQ-019 CPU-only read: c_req=1, c_addr=0x40, mem returns 0xDEADBEEF -> c_gnt=1 in cycle 0; c_rvalid=1, c_rdata=0xDEADBEEF in cycle 1; d_gnt stays 0.
REQ-020 First tie after reset: both req in cycle 0 -> c_gnt=1. Both held continuously -> subsequent grants are D,D,D,D,C,D,D,D,D,C.
REQ-021 Write no-return: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x5A5A5A5A -> mem_we=1 with those values; d_rvalid stays 0 the next cycle.
REQ-022 Back-to-back reads: CPU reads 0x0 then 0x4 in consecutive cycles -> two consecutive c_rvalid pulses with matching data order.
REQ-023 Reset mid-read: CPU read granted, then reset=0 before the next edge -> c_rvalid never asserts; after release, a tie grants the CPU.
REQ-024 Burst saturation: the DMA alone for 10 cycles -> burst_cnt=MAX_BURST (4), no overflow; then a CPU request -> c_gnt in the first tie cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Default bus widths used by mem_arbiter when not overridden.
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Requester identity; used both for the "last granted" state and for
    // the read-return tag.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_burst_ctr.sv
// Grant decision for CPU vs DMA plus last-owner / DMA burst counter state.
// Latency: grant is combinational from req; state updates on the granting edge.
// Backpressure: a requester not selected simply stays un-granted; no state change on idle.
//
// Ports: clk, reset (async active-low), c_req/d_req (qualified requests),
//        c_sel/d_sel (one-hot-or-zero grant for this cycle).
module arb_burst_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    localparam int CNT_W    = $clog2(MAX_BURST) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic c_req,
    input  logic d_req,
    output logic c_sel,
    output logic d_sel
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    owner_t           last;
    logic [CNT_W-1:0] burst_cnt;
    logic             dma_turn;

    // On a tie the DMA keeps the bus after a CPU grant, or while its burst
    // is still short of MAX_BURST. last=DMA with an empty count only exists
    // straight out of reset (every DMA grant leaves the count >= 1), and is
    // treated as the CPU's turn so the CPU wins the first tie after reset.
    always_comb begin
        dma_turn = (last == OWN_CPU) ||
                   ((burst_cnt != '0) && (burst_cnt < CNT_MAX));
        d_sel    = d_req && (!c_req || dma_turn);
        c_sel    = c_req && !d_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last      <= OWN_DMA;
            burst_cnt <= '0;
        end else if (d_sel) begin
            last <= OWN_DMA;
            if (last == OWN_DMA) begin
                burst_cnt <= (burst_cnt == CNT_MAX) ? CNT_MAX
                                                    : burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt <= CNT_W'(1);
            end
        end else if (c_sel) begin
            last      <= OWN_CPU;
            burst_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU, DMA) arbiter onto a single synchronous memory port.
// Latency: grant and memory strobe same cycle; read data returns 1 cycle later.
// Backpressure: un-granted requester holds its request; at most one grant per cycle.
//
// Ports: clk, reset (async active-low);
//        c_* / d_* : req, we, addr, wdata in; gnt, rvalid, rdata out;
//        mem_*     : en, we, addr, wdata out; rdata in (valid 1 cycle after en).
module mem_arbiter #(
    parameter int ADDR_W    = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W    = mem_arbiter_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_arbiter_pkg::*;

    logic   c_req_q;
    logic   d_req_q;
    logic   rd_pend;
    owner_t rd_own;

    // Requests are masked by reset so no grant or memory strobe can leak
    // out while reset is held, even though the grant path is combinational.
    assign c_req_q = c_req && reset;
    assign d_req_q = d_req && reset;

    arb_burst_ctr #(
        .MAX_BURST (MAX_BURST)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .c_req (c_req_q),
        .d_req (d_req_q),
        .c_sel (c_gnt),
        .d_sel (d_gnt)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (c_gnt) begin
            mem_en    = 1'b1;
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end
    end

    // Read-return tag: remembers who issued the read now completing in the
    // memory so its data is steered back to the right requester. Async reset
    // drops any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend <= 1'b0;
            rd_own  <= OWN_CPU;
        end else begin
            rd_pend <= mem_en && !mem_we;
            if (mem_en) begin
                rd_own <= d_gnt ? OWN_DMA : OWN_CPU;
            end
        end
    end

    assign c_rvalid = rd_pend && (rd_own == OWN_CPU);
    assign d_rvalid = rd_pend && (rd_own == OWN_DMA);
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous memory model: address 0x40 holds 0xDEADBEEF, every other
    // address reads as {addr[15:0], ~addr[15:0]}.
    always @(posedge clk) begin
        if (mem_en && !mem_we) begin
            if (mem_addr == 32'h40) mem_rdata <= 32'hDEADBEEF;
            else                    mem_rdata <= {mem_addr[15:0], ~mem_addr[15:0]};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic expc;
        logic prevc;

        // ---- reset with requests active: everything must stay quiet ----
        reset = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h33; c_wdata = 32'h77;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h88;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_c_gnt",    c_gnt,     0);
        chk("rst_d_gnt",    d_gnt,     0);
        chk("rst_c_rvalid", c_rvalid,  0);
        chk("rst_d_rvalid", d_rvalid,  0);
        chk("rst_mem_en",   mem_en,    0);
        chk("rst_mem_we",   mem_we,    0);
        chk("rst_mem_addr", mem_addr,  0);
        chk("rst_mem_wd",   mem_wdata, 0);

        // ---- release; both read continuously: C,D,D,D,D,C,D,D,D,D,C ----
        @(negedge clk);
        reset = 1'b1;
        c_we = 1'b0; c_addr = 32'h10;
        d_we = 1'b0; d_addr = 32'h20;
        prevc = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            expc = (i % 5 == 0);
            chk("tie_c_gnt", c_gnt, expc);
            chk("tie_d_gnt", d_gnt, !expc);
            if (i > 0) begin
                chk("tie_c_rvalid", c_rvalid, prevc);
                chk("tie_d_rvalid", d_rvalid, !prevc);
                chk("tie_c_rdata",  c_rdata, prevc ? 32'h0010FFEF : 32'h0);
                chk("tie_d_rdata",  d_rdata, prevc ? 32'h0 : 32'h0020FFDF);
            end
            prevc = expc;
        end
        @(negedge clk);
        c_req = 1'b0; d_req = 1'b0;
        #1;
        chk("tie_last_c_rvalid", c_rvalid, 1);
        chk("idle_mem_en",       mem_en,   0);
        chk("idle_mem_we",       mem_we,   0);

        // ---- CPU-only read of 0x40 ----
        @(negedge clk);
        c_req = 1'b1; c_addr = 32'h40;
        #1;
        chk("cpu_rd_c_gnt",    c_gnt,    1);
        chk("cpu_rd_d_gnt",    d_gnt,    0);
        chk("cpu_rd_mem_en",   mem_en,   1);
        chk("cpu_rd_mem_we",   mem_we,   0);
        chk("cpu_rd_mem_addr", mem_addr, 32'h40);
        @(negedge clk);
        c_req = 1'b0;
        #1;
        chk("cpu_rd_rvalid", c_rvalid, 1);
        chk("cpu_rd_rdata",  c_rdata,  32'hDEADBEEF);
        chk("cpu_rd_d_rv",   d_rvalid, 0);
        chk("cpu_rd_d_gnt2", d_gnt,    0);
        @(negedge clk); #1;
        chk("cpu_rd_rv_once", c_rvalid, 0);
        chk("cpu_rd_rdata0",  c_rdata,  0);

        // ---- DMA write, no read return ----
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h5A5A5A5A;
        #1;
        chk("dma_wr_d_gnt",  d_gnt,     1);
        chk("dma_wr_c_gnt",  c_gnt,     0);
        chk("dma_wr_mem_we", mem_we,    1);
        chk("dma_wr_addr",   mem_addr,  32'h100);
        chk("dma_wr_wdata",  mem_wdata, 32'h5A5A5A5A);
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("dma_wr_no_rv", d_rvalid, 0);
        chk("dma_wr_no_crv", c_rvalid, 0);

        // ---- back-to-back CPU reads 0x0 then 0x4 ----
        @(negedge clk);
        c_req = 1'b1; c_addr = 32'h0;
        #1;
        chk("b2b_gnt0", c_gnt, 1);
        @(negedge clk);
        c_addr = 32'h4;
        #1;
        chk("b2b_gnt1",   c_gnt,    1);
        chk("b2b_rv0",    c_rvalid, 1);
        chk("b2b_rdata0", c_rdata,  32'h0000FFFF);
        @(negedge clk);
        c_req = 1'b0;
        #1;
        chk("b2b_rv1",    c_rvalid, 1);
        chk("b2b_rdata1", c_rdata,  32'h0004FFFB);
        @(negedge clk); #1;
        chk("b2b_rv_end", c_rvalid, 0);

        // ---- DMA alone for 10 cycles: counter saturates, CPU wins next tie ----
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("burst_d_gnt", d_gnt, 1);
        end
        @(negedge clk);
        #1;
        chk("burst_cnt_sat", u_dut.u_ctr.burst_cnt, 4);
        c_req = 1'b1; c_addr = 32'h40;
        #1;
        chk("burst_tie_c_gnt", c_gnt,    1);
        chk("burst_tie_d_gnt", d_gnt,    0);
        chk("burst_d_rvalid",  d_rvalid, 1);
        chk("burst_d_rdata",   d_rdata,  32'h0200FDFF);
        @(negedge clk);
        c_req = 1'b0; d_req = 1'b0;
        #1;
        chk("burst_c_rvalid", c_rvalid, 1);

        // ---- reset while a CPU read is in flight ----
        @(negedge clk);
        c_req = 1'b1; c_addr = 32'h8;
        #1;
        chk("mid_rst_gnt", c_gnt, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt_masked", c_gnt,  0);
        chk("mid_rst_mem_en",     mem_en, 0);
        @(negedge clk); #1;
        chk("mid_rst_rv_in_rst", c_rvalid, 0);
        @(negedge clk);
        reset = 1'b1; c_req = 1'b0;
        #1;
        chk("mid_rst_rv_rel0", c_rvalid, 0);
        @(negedge clk); #1;
        chk("mid_rst_rv_rel1", c_rvalid, 0);
        @(negedge clk);
        c_req = 1'b1; d_req = 1'b1;
        #1;
        chk("mid_rst_tie_c", c_gnt, 1);
        chk("mid_rst_tie_d", d_gnt, 0);
        @(negedge clk);
        c_req = 1'b0; d_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
